kernel_weight_writer: RTL and testbench

//  Write side of the CNN kernel weight store. Accepts a valid/ready stream of k_size weights

---
 rtl/kernel_pkg.sv | 25 ++
 rtl/kernel_checksum_acc.sv | 35 +++
 rtl/kernel_weight_writer.sv | 156 +++++++++++++++
 tb/tb_kernel_weight_writer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : kernel_pkg                                                       |
// | Shared types for the CNN kernel weight store (writer and reader sides).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package kernel_pkg;

  localparam int K_SIZE_3X3 = 9;
  localparam int WEIGHT_W   = 16;

  typedef logic [WEIGHT_W-1:0] weight_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } kw_state_e;

endpackage

`default_nettype wire

// File: rtl/kernel_checksum_acc.sv
// +----------------------------------------------------------------------------+
// | Module  : kernel_checksum_acc                                              |
// | Running sum (mod 2^WIDTH) of accepted kernel weights.                      |
// | Used only when KERNEL_WRITER_CHECKSUM_EN is defined.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module kernel_checksum_acc #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             add_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] sum_q;

  // Clear at kernel start, otherwise add each accepted weight (natural wrap)
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

`default_nettype wire

// File: rtl/kernel_weight_writer.sv
// +----------------------------------------------------------------------------+
// | Module  : kernel_weight_writer                                             |
// | Write side of the kernel weight store: takes a valid/ready stream of       |
// | K_SIZE weights and issues one registered RAM write per weight, reporting   |
// | short/long frames through a sticky error flag.                             |
// | Optional: KERNEL_WRITER_CHECKSUM_EN adds a trailing checksum word.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module kernel_weight_writer
  import kernel_pkg::*;
#(
  parameter  int WIDTH  = WEIGHT_W,
  parameter  int K_SIZE = K_SIZE_3X3,
  localparam int AW     = $clog2(K_SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_last_i,
  output logic             w_en_o,
  output logic [AW-1:0]    w_addr_o,
  output logic [WIDTH-1:0] w_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [AW-1:0] c_last_idx = AW'(K_SIZE - 1);

  kw_state_e        state_q;
  logic [AW-1:0]    count_q;
  logic             w_en_q;
  logic [AW-1:0]    w_addr_q;
  logic [WIDTH-1:0] w_data_q;
  logic             done_q;
  logic             err_q;
  logic             w_hs;

  // Stream is open while loading, checking or discarding a frame
  assign s_ready_o = (state_q == LOAD) || (state_q == CHECK) || (state_q == DRAIN);
  assign w_hs      = s_valid_i && s_ready_o;

`ifdef KERNEL_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0] w_sum;

  kernel_checksum_acc #(
    .WIDTH (WIDTH)
  ) u_checksum_acc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  ((state_q == IDLE) && start_i),
    .add_en_i ((state_q == LOAD) && w_hs),
    .data_i   (s_data_i),
    .sum_o    (w_sum)
  );
`endif

  // Frame FSM with write port, done pulse and sticky error registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      w_en_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_hs) begin
            w_en_q   <= 1'b1;
            w_addr_q <= count_q;
            w_data_q <= s_data_i;
            if (count_q != c_last_idx) begin
              count_q <= count_q + AW'(1);
              if (s_last_i) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            end else begin
`ifdef KERNEL_WRITER_CHECKSUM_EN
              // The checksum word must follow, so s_last here ends the frame early
              if (s_last_i) begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                state_q <= CHECK;
              end
`else
              if (s_last_i) begin
                state_q <= DONE;
              end else begin
                err_q   <= 1'b1;
                state_q <= DRAIN;
              end
`endif
            end
          end
        end
        CHECK: begin
`ifdef KERNEL_WRITER_CHECKSUM_EN
          if (w_hs) begin
            if (s_data_i != w_sum) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (s_last_i) begin
              state_q <= DONE;
            end else begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end
          end
`else
          state_q <= IDLE;
`endif
        end
        DRAIN: begin
          if (w_hs && s_last_i) begin
            state_q <= IDLE;
          end
        end
        DONE: begin
          // DONE overlaps the final write cycle; the pulse lands one cycle later
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign w_en_o   = w_en_q;
  assign w_addr_o = w_addr_q;
  assign w_data_o = w_data_q;
  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_kernel_weight_writer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_kernel_weight_writer                                          |
// | Self-checking bench for kernel_weight_writer (default 16-bit, 3x3).        |
// | Honours KERNEL_WRITER_CHECKSUM_EN for the checksum scenarios.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_kernel_weight_writer;

  localparam int K = 9;

  logic        clk = 1'b0;
  logic        rst, start, s_valid, s_last;
  logic [15:0] s_data;
  logic        s_ready, w_en, busy, done, err;
  logic [3:0]  w_addr;
  logic [15:0] w_data;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  kernel_weight_writer dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .w_en_o    (w_en),
    .w_addr_o  (w_addr),
    .w_data_o  (w_data),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed RAM writes and done pulses
  int got_addr[$], got_data[$], got_cyc[$], hs_cyc[$];
  int done_cnt, done_cyc;
  always @(negedge clk) begin
    if (w_en) begin
      got_addr.push_back(int'(w_addr));
      got_data.push_back(int'(w_data));
      got_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Current frame and reference expectations
  logic [15:0] fr_data[$];
  bit          fr_last[$];
  int          exp_addr[$], exp_data[$];
  bit          exp_err, exp_done;

  task automatic make_frame(input int n, input bit seq);
    fr_data.delete();
    fr_last.delete();
    for (int i = 0; i < n; i++) begin
      fr_data.push_back(seq ? 16'(i + 1) : 16'($urandom));
      fr_last.push_back(i == n - 1);
    end
`ifdef KERNEL_WRITER_CHECKSUM_EN
    if (n >= K) begin
      logic [15:0] s;
      s = 16'd0;
      for (int i = 0; i < K; i++) s += fr_data[i];
      fr_last[K-1] = 1'b0;
      fr_data.insert(K, s);
      fr_last.insert(K, n == K);
    end
`endif
  endtask

  // Frame rules: words 0..K-1 are written; s_last placement and (optionally)
  // the checksum word decide between done, error, and draining to s_last.
  function automatic void model();
    logic [15:0] sum;
    bit drain;
    sum = 16'd0;
    drain = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    exp_err  = 1'b0;
    exp_done = 1'b0;
    for (int i = 0; i < fr_data.size(); i++) begin
      if (drain) begin
        if (fr_last[i]) break;
        continue;
      end
      if (i < K) begin
        exp_addr.push_back(i);
        exp_data.push_back(int'(fr_data[i]));
        sum += fr_data[i];
      end
      if (i < K - 1) begin
        if (fr_last[i]) begin exp_err = 1'b1; break; end
      end else if (i == K - 1) begin
`ifdef KERNEL_WRITER_CHECKSUM_EN
        if (fr_last[i]) begin exp_err = 1'b1; break; end
`else
        if (fr_last[i]) begin exp_done = 1'b1; break; end
        exp_err = 1'b1;
        drain = 1'b1;
`endif
      end else begin
        if (fr_data[i] != sum) begin exp_err = 1'b1; break; end
        if (fr_last[i]) begin exp_done = 1'b1; break; end
        exp_err = 1'b1;
        drain = 1'b1;
      end
    end
  endfunction

  // gap < 0: exactly one idle cycle before every word; else random 0..gap
  task automatic send_frame(input int gap, input int busy_start_idx);
    bit acc;
    int g;
    got_addr.delete(); got_data.delete(); got_cyc.delete(); hs_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < fr_data.size(); i++) begin
      g = (gap < 0) ? 1 : $urandom_range(0, gap);
      repeat (g) begin s_valid = 1'b0; @(posedge clk); #1; end
      s_valid = 1'b1;
      s_data  = fr_data[i];
      s_last  = fr_last[i];
      start   = (i == busy_start_idx);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        @(negedge clk);
        if (s_ready) begin acc = 1'b1; hs_cyc.push_back(cyc); end
        @(posedge clk); #1;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      start   = 1'b0;
      if (!acc) begin
        checks++; errors++;
        $display("FAIL handshake timeout: word %0d not accepted, required accept within 20 cycles", i);
        break;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, w_en, busy, done, err, w_addr, w_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b en=%b busy=%b done=%b err=%b addr=%0d data=%h required all 0",
               s_ready, w_en, busy, done, err, w_addr, w_data);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    make_frame(K, 1'b1);
    model();
    send_frame(0, 3);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL nominal write_count: got %0d required %0d", got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i] || got_cyc[i] != hs_cyc[i] + 1) begin
        errors++;
        $display("FAIL nominal write[%0d]: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], hs_cyc[i] + 1);
      end
    end
    checks++;
    if (done_cnt != int'(exp_done) || err !== exp_err) begin
      errors++;
      $display("FAIL nominal status: got done_cnt=%0d err=%b required %0d %b", done_cnt, err, exp_done, exp_err);
    end
`ifndef KERNEL_WRITER_CHECKSUM_EN
    if (got_cyc.size() > 0) begin
      checks++;
      if (done_cyc != got_cyc[got_cyc.size()-1] + 1) begin
        errors++;
        $display("FAIL nominal done_timing: got cyc %0d required %0d", done_cyc, got_cyc[got_cyc.size()-1] + 1);
      end
    end
`endif
    checks++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nominal idle_after: got rdy=%b busy=%b required 0 0", s_ready, busy);
    end
  endtask

  // Frame scenarios sharing the same expectation checks
  task automatic test_frame(input string name, input int n, input int gap);
    make_frame(n, 1'b0);
    model();
    send_frame(gap, -1);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i] || got_cyc[i] != hs_cyc[i] + 1) begin
        errors++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h cyc=%0d required addr=%0d data=%h cyc=%0d",
                 name, i, got_addr[i], got_data[i], got_cyc[i], exp_addr[i], exp_data[i], hs_cyc[i] + 1);
      end
    end
    checks++;
    if (done_cnt != int'(exp_done) || err !== exp_err || s_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s status: got done_cnt=%0d err=%b rdy=%b busy=%b required %0d %b 0 0",
               name, done_cnt, err, s_ready, busy, exp_done, exp_err);
    end
  endtask

  task automatic test_mid_reset();
    fr_data.delete();
    fr_last.delete();
    for (int i = 0; i < 5; i++) begin
      fr_data.push_back(16'($urandom));
      fr_last.push_back(1'b0);
    end
    got_addr.delete(); got_data.delete(); got_cyc.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = fr_data[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, w_en, busy, done, err, w_addr, w_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset outputs: got rdy=%b en=%b busy=%b done=%b err=%b addr=%0d data=%h required all 0",
               s_ready, w_en, busy, done, err, w_addr, w_data);
    end
    checks++;
    if (got_addr.size() != 5 || (got_addr.size() == 5 && got_addr[4] != 4)) begin
      errors++;
      $display("FAIL mid_reset writes: got count %0d required 5 ending at addr 4", got_addr.size());
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    test_frame("after_reset", K, 1);
  endtask

`ifdef KERNEL_WRITER_CHECKSUM_EN
  task automatic test_checksum(input logic [15:0] ck);
    fr_data.delete();
    fr_last.delete();
    for (int i = 0; i < K; i++) begin
      fr_data.push_back(16'h1000);
      fr_last.push_back(1'b0);
    end
    fr_data.push_back(ck);
    fr_last.push_back(1'b1);
    model();
    send_frame(1, 4);
    checks++;
    if (got_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL checksum %h write_count: got %0d required %0d", ck, got_addr.size(), exp_addr.size());
    end
    checks++;
    if (done_cnt != int'(exp_done) || err !== exp_err) begin
      errors++;
      $display("FAIL checksum %h status: got done_cnt=%0d err=%b required %0d %b", ck, done_cnt, err, exp_done, exp_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_frame("backpressure", K, -1);
    test_frame("short", 5, 2);
    test_frame("long", 12, 1);
    test_mid_reset();
`ifdef KERNEL_WRITER_CHECKSUM_EN
    test_checksum(16'h9000);
    test_checksum(16'h9001);
`endif
    for (int r = 0; r < 6; r++) test_frame("random", $urandom_range(1, 13), 2);
    test_frame("back_to_back", K, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
